// File: rtl/rv32_inst_encoder_if.sv
// rv32_inst_encoder_if
// Groups the encoder's two streaming handshakes.
//   input side  : in_valid_i / in_ready_o plus the decoded fields
//                 op_i, rs1_i, rs2_i, rd_i, imm_i
//   output side : out_valid_o / out_ready_i plus out_inst_o, out_addr_o
// The field names keep the _i/_o suffixes as seen from the encoder.
// master = sequencer/program-loader side, slave = encoder.
// ADDR_W must match the encoder's ADDR_W parameter.
interface rv32_inst_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [4:0]        op_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [4:0]        rd_i;
  logic [31:0]       imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_inst_o;
  logic [ADDR_W-1:0] out_addr_o;

  modport master (
    output in_valid_i, op_i, rs1_i, rs2_i, rd_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_inst_o, out_addr_o
  );

  modport slave (
    input  in_valid_i, op_i, rs1_i, rs2_i, rd_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, out_inst_o, out_addr_o
  );
endinterface

// File: rtl/rv32_inst_encoder.sv
// rv32_inst_encoder
// Packs decoded-form fields (op, rs1, rs2, rd, imm) into RV32I(+MUL)
// instruction words, buffers them in a DEPTH-entry FIFO and emits each word
// with a sequential instruction-memory word address.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clear_i    : synchronous flush (FIFO emptied, address back to BASE_ADDR)
//   bus        : rv32_inst_encoder_if.slave (input fields + output words)
//   err_o      : one-cycle pulse, cycle after an accepted bundle is dropped
//   err_cnt_o  : saturating (255) count of dropped bundles; not flushed
//
// Parameters: DEPTH (power of two, >= 2), ADDR_W, BASE_ADDR.
//
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined     : out-of-range immediates are dropped like illegal ops
//   not defined : immediates are truncated to their field bits
module rv32_inst_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  rv32_inst_encoder_if.slave   bus,
  output logic                 err_o,
  output logic [7:0]           err_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J} fmt_t;

  fmt_t        fmt;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        illegal_op;
  logic        range_bad;
  logic [31:0] enc_word;
  logic [31:0] imm;

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              err_reg;
  logic [7:0]        err_cnt_reg;
  logic [31:0]       entry_word [DEPTH];

  logic accept;
  logic push;
  logic pop;
  logic drop;

  assign imm = bus.imm_i;

  // Operation -> instruction format, opcode and funct fields.
  always_comb begin
    fmt        = FMT_R;
    opcode     = 7'h33;
    funct7     = 7'h00;
    funct3     = 3'b000;
    illegal_op = 1'b0;
    case (bus.op_i)
      5'd0:  ;                                                 // ADD
      5'd1:  funct7 = 7'h20;                                   // SUB
      5'd2:  funct3 = 3'b001;                                  // SLL
      5'd3:  funct3 = 3'b010;                                  // SLT
      5'd4:  funct3 = 3'b100;                                  // XOR
      5'd5:  funct3 = 3'b101;                                  // SRL
      5'd6:  begin funct3 = 3'b101; funct7 = 7'h20; end        // SRA
      5'd7:  funct3 = 3'b110;                                  // OR
      5'd8:  funct3 = 3'b111;                                  // AND
      5'd9:  funct7 = 7'h01;                                   // MUL
      5'd10: begin fmt = FMT_I;  opcode = 7'h13; end           // ADDI
      5'd11: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'b010; end
      5'd12: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'b100; end
      5'd13: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'b110; end
      5'd14: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'b111; end
      5'd15: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'b001; end
      5'd16: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'b101; end
      5'd17: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'b101; funct7 = 7'h20; end
      5'd18: begin fmt = FMT_I;  opcode = 7'h03; funct3 = 3'b010; end  // LW
      5'd19: begin fmt = FMT_S;  opcode = 7'h23; funct3 = 3'b010; end  // SW
      5'd20: begin fmt = FMT_B;  opcode = 7'h63; end                   // BEQ
      5'd21: begin fmt = FMT_B;  opcode = 7'h63; funct3 = 3'b001; end  // BNE
      5'd22: begin fmt = FMT_J;  opcode = 7'h6F; end                   // JAL
      5'd23: begin fmt = FMT_I;  opcode = 7'h67; end                   // JALR
      default: illegal_op = 1'b1;
    endcase
  end

  // Field packing. Register fields a format does not carry simply have no
  // slot in the word, so they come out as zero / immediate bits.
  always_comb begin
    enc_word = 32'd0;
    case (fmt)
      FMT_R:  enc_word = {funct7, bus.rs2_i, bus.rs1_i, funct3, bus.rd_i, opcode};
      FMT_I:  enc_word = {imm[11:0], bus.rs1_i, funct3, bus.rd_i, opcode};
      FMT_SH: enc_word = {funct7, imm[4:0], bus.rs1_i, funct3, bus.rd_i, opcode};
      FMT_S:  enc_word = {imm[11:5], bus.rs2_i, bus.rs1_i, funct3, imm[4:0], opcode};
      FMT_B:  enc_word = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, funct3,
                          imm[4:1], imm[11], opcode};
      FMT_J:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, opcode};
      default: enc_word = 32'd0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = $signed(bus.imm_i);

  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      FMT_SH:       range_bad = |imm[31:5];
      FMT_B:        range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
      FMT_J:        range_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
      default:      range_bad = 1'b0;
    endcase
  end
`else
  // Upper immediate bits have no field slot when no range check is made.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];
  assign range_bad     = 1'b0;
`endif

  // Flush wins over everything arriving in the same cycle, including errors.
  assign accept = bus.in_valid_i && bus.in_ready_o && !clear_i;
  assign push   = accept && !illegal_op && !range_bad;
  assign drop   = accept && (illegal_op || range_bad);
  assign pop    = bus.out_valid_o && bus.out_ready_i && !clear_i;

  // Readiness depends only on the registered count: a pop in the same cycle
  // does not open a slot, which keeps out_ready_i off the in_ready_o path.
  assign bus.in_ready_o  = (count_reg != DEPTH_CNT);
  assign bus.out_valid_o = (count_reg != '0);
  assign bus.out_inst_o  = entry_word[rd_ptr_reg];
  assign bus.out_addr_o  = addr_reg;
  assign err_o           = err_reg;
  assign err_cnt_o       = err_cnt_reg;

  // FIFO storage: one word register per entry, written when the tail points
  // at it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0] word_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_reg <= 32'd0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        word_reg <= enc_word;
      end
    end
    assign entry_word[gi] = word_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      addr_reg    <= BASE;
      err_reg     <= 1'b0;
      err_cnt_reg <= 8'd0;
    end else begin
      err_reg <= drop;
      if (drop && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
      if (clear_i) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        addr_reg   <= BASE;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          addr_reg   <= addr_reg + 1'b1;   // wraps modulo 2^ADDR_W
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

endmodule

// File: doc/rv32_inst_encoder.md
# rv32_inst_encoder

Streaming RV32I(+MUL) instruction encoder: the inverse of the core's instruction decoder. It accepts decoded-form fields (operation, rs1, rs2, rd, immediate) over a valid/ready handshake and packs them into 32-bit instruction words. Words are buffered in a small FIFO and emitted with a sequential instruction-memory word address. It sits between the self-test/program-loader sequencer and the instruction memory write port. It generates exactly the instruction subset the decoder understands.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 10: word-address width.
- `BASE_ADDR`, 0: first emitted word address.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset; asynchronous and active-high.
- `clear_i` input 1: synchronous flush; empties the FIFO and reloads the address to `BASE_ADDR`.
- `in_valid_i` input 1: field bundle valid.
- `in_ready_o` output 1: bundle accepted when `in_valid_i` and `in_ready_o` are both high.
- `op_i` input 5: operation code. 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 XOR, 5 SRL, 6 SRA, 7 OR, 8 AND, 9 MUL, 10 ADDI, 11 SLTI, 12 XORI, 13 ORI, 14 ANDI, 15 SLLI, 16 SRLI, 17 SRAI, 18 LW, 19 SW, 20 BEQ, 21 BNE, 22 JAL, 23 JALR. Values 24–31 are illegal.
- `rs1_i`, `rs2_i`, `rd_i` input 5 each: register fields.
- `imm_i` input 32: signed immediate, byte offset for branches and JAL.
- `out_valid_o` output 1: head word valid.
- `out_ready_i` input 1: memory accepts the head word.
- `out_inst_o` output 32: encoded word.
- `out_addr_o` output ADDR_W: word address of `out_inst_o`.
- `err_o` output 1: one-cycle pulse when an accepted bundle is dropped.
- `err_cnt_o` output 8: saturating count of dropped bundles.

## Operation
- Opcodes and funct values:
  - R-type: 0x33. SUB and SRA use funct7 0x20; MUL uses funct7 0x01 with funct3 000.
  - I-type ALU: 0x13. SRAI uses imm[11:5]=0x20; SLLI/SRLI use 0x00, with shamt from imm_i[4:0].
  - LW: 0x03, funct3 010. SW: 0x23, funct3 010.
  - BEQ/BNE: 0x63, funct3 000/001. JAL: 0x6F. JALR: 0x67, funct3 000.
- Field handling: unused register fields are encoded as 0. The encoding of each accepted bundle is computed combinationally and written into the FIFO tail in the acceptance cycle.
- Drop conditions: illegal `op_i`, or a range violation (see Configuration). On a drop, nothing is written, no address is consumed, `err_o` pulses the next cycle, and `err_cnt_o` increments and saturates at 255.
- `in_ready_o` = FIFO count < DEPTH. It is low when the FIFO is full, even if a pop happens in the same cycle; there is no full-bypass.
- `out_valid_o` = count > 0. `out_inst_o` is the FIFO head, and it stays stable while valid and not ready.
- Output handshake: `out_addr_o` increments on each output handshake and wraps modulo 2^ADDR_W.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- `clear_i` has priority over push, pop and error in the same cycle: that cycle's input is discarded and no `err_o` is raised. `err_cnt_o` is not cleared.
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `out_inst_o`=0, `out_addr_o`=BASE_ADDR, `err_o`=0, `err_cnt_o`=0, FIFO empty.
- Reset mid-stream: buffered words are lost, and the address restarts at BASE_ADDR.

## Timing
- Latency: a bundle accepted in cycle N gives `out_valid_o`=1 in cycle N+1 if the FIFO was empty.
- Throughput: one word per cycle sustained when `out_ready_i` is held high.
- The error pulse appears in cycle N+1 for a drop in cycle N.
- No combinational path from `out_ready_i` to `in_ready_o`. No combinational path from inputs to `out_*`.

## Configuration
- `ENC_RANGE_CHECK_EN` defined: the following are drop conditions.
  - I/S-type imm outside −2048..2047.
  - Shift imm[31:5]≠0.
  - B-type imm outside −4096..4094, or imm[0]=1.
  - JAL imm outside −2^20..2^20−2, or imm[0]=1.
- Not defined: immediates are truncated to their field bits without checking, and only an illegal op causes a drop.

## Test plan
- Reset, then push op 10 (ADDI) with rd=1, rs1=0, imm=5. Required: out 0x00500093 at addr 0, valid one cycle after acceptance.
- Push ADD, SUB, MUL with rd=3, rs1=1, rs2=2, with `out_ready_i`=1. Required: 0x002081B3, 0x402081B3, 0x022081B3 at addrs 0, 1, 2, back-to-back.
- Push SW (rs1=1, rs2=2, imm=8), BEQ (rs1=1, rs2=2, imm=8), JAL (rd=1, imm=16), SRAI (rd=4, rs1=4, imm=3). Required: 0x0020A423, 0x00208463, 0x010000EF, 0x40325213.
- Hold `out_ready_i`=0 and push 5 bundles with DEPTH=4. Required: `in_ready_o` drops after the 4th, the head stays stable, and releasing ready drains in order.
- Push op 25, then, with the macro on, ADDI imm=4096 and BEQ imm=3. Required: three `err_o` pulses, `err_cnt_o`=3, no output, and the address is not advanced.
- Set ADDR_W=2 and emit 5 words. Required: addresses 0, 1, 2, 3, 0. Assert `clear_i` with 2 words buffered. Required: `out_valid_o`=0 and the next word is emitted at BASE_ADDR.
